// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scan controller.
//   scan_state_e : scan FSM states
//   KEY_MAP      : hex code for each (row, column) position
//   key_code     : (row index, column index) -> hex code
//   single_low   : true when exactly one active-low row is asserted
//   low_row      : index of the asserted row in a single-low pattern
//   col_drive    : one-hot-low column drive for a column index
//   max_u        : unsigned maximum, used for counter sizing
package keypad_pkg;

    localparam int unsigned ROWS   = 4;
    localparam int unsigned COLS   = 4;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned CODE_W = 4;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } scan_state_e;

    // Indexed [row][column]
    localparam logic [CODE_W-1:0] KEY_MAP [ROWS][COLS] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    function automatic logic [CODE_W-1:0] key_code(input logic [IDX_W-1:0] row,
                                                   input logic [IDX_W-1:0] col);
        return KEY_MAP[row][col];
    endfunction

    function automatic logic single_low(input logic [ROWS-1:0] rows);
        int unsigned n;
        n = 0;
        for (int i = 0; i < int'(ROWS); i++) begin
            if (!rows[i]) n++;
        end
        return (n == 1);
    endfunction

    function automatic logic [IDX_W-1:0] low_row(input logic [ROWS-1:0] rows);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < int'(ROWS); i++) begin
            if (!rows[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [COLS-1:0] col_drive(input logic [IDX_W-1:0] col);
        return ~(COLS'(1) << col);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/keyscan_timer.sv
// Loadable up-counter with terminal-count flag, shared by the settle and
// debounce phases. Counts from 0 and saturates at limit (never wraps).
//   int_osc : clock
//   reset   : asynchronous active-high reset (count = 0)
//   clear   : synchronous load of 0
//   limit   : terminal count value
//   done_c  : combinational flag, count == limit
module keyscan_timer #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             int_osc,
    input  logic             reset,
    input  logic             clear,
    input  logic [WIDTH-1:0] limit,
    output logic             done_c
);

    logic [WIDTH-1:0] count;

    // Saturating counter
    always_ff @(posedge int_osc or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count != limit) begin
            count <= count + WIDTH'(1);
        end
    end

    assign done_c = (count == limit);

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Scan controller for a 4x4 matrix keypad. Drives one column low at a time,
// samples synchronized rows after a settle time, debounces a single key on
// press and on release, and reports the hex code with a one-cycle strobe.
// SETTLE_CYCLES and DEBOUNCE_CYCLES must both be >= 2.
//   int_osc   : clock
//   reset     : asynchronous active-high reset
//   sync_rows : synchronized rows, active-low
//   cols      : column drives, active-low one-hot
//   key       : hex code of the last accepted key
//   key_valid : one-cycle strobe per accepted press
//   key_held  : high while the accepted key is down or releasing
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES   = 4096,
    parameter int unsigned DEBOUNCE_CYCLES = 200000
) (
    input  logic              int_osc,
    input  logic              reset,
    input  logic [ROWS-1:0]   sync_rows,
    output logic [COLS-1:0]   cols,
    output logic [CODE_W-1:0] key,
    output logic              key_valid,
    output logic              key_held
);

    localparam int unsigned CNT_MAX = max_u(SETTLE_CYCLES, DEBOUNCE_CYCLES);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);

    scan_state_e       state, state_next;
    logic [IDX_W-1:0]  col, col_next;
    logic [IDX_W-1:0]  row, row_next;
    logic [ROWS-1:0]   pattern, pattern_next;
    logic [COLS-1:0]   cols_next;
    logic [CODE_W-1:0] key_next;
    logic              valid_next;
    logic              held_next;

    logic              timer_clear_c;
    logic              timer_done_c;
    logic [CNT_W-1:0]  timer_limit_c;

    keyscan_timer #(
        .WIDTH (CNT_W)
    ) u_timer (
        .int_osc (int_osc),
        .reset   (reset),
        .clear   (timer_clear_c),
        .limit   (timer_limit_c),
        .done_c  (timer_done_c)
    );

    // State and output registers
    always_ff @(posedge int_osc or posedge reset) begin
        if (reset) begin
            state     <= SCAN;
            col       <= '0;
            row       <= '0;
            pattern   <= '1;
            cols      <= 4'b1110;
            key       <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_next;
            col       <= col_next;
            row       <= row_next;
            pattern   <= pattern_next;
            cols      <= cols_next;
            key       <= key_next;
            key_valid <= valid_next;
            key_held  <= held_next;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_next    = state;
        col_next      = col;
        row_next      = row;
        pattern_next  = pattern;
        key_next      = key;
        valid_next    = 1'b0;
        timer_clear_c = 1'b0;
        timer_limit_c = (state == SCAN) ? CNT_W'(SETTLE_CYCLES - 1)
                                        : CNT_W'(DEBOUNCE_CYCLES - 1);

        case (state)
            SCAN: begin
                if (timer_done_c) begin
                    timer_clear_c = 1'b1;
                    if (single_low(sync_rows)) begin
                        pattern_next = sync_rows;
                        row_next     = low_row(sync_rows);
                        state_next   = DEBOUNCE;
                    end else begin
                        col_next = col + IDX_W'(1);
                    end
                end
            end

            DEBOUNCE: begin
                if (sync_rows != pattern) begin
                    state_next    = SCAN;
                    col_next      = col + IDX_W'(1);
                    timer_clear_c = 1'b1;
                end else if (timer_done_c) begin
                    state_next    = PRESSED;
                    key_next      = key_code(row, col);
                    valid_next    = 1'b1;
                    timer_clear_c = 1'b1;
                end
            end

            // Only the captured row matters; other keys are ignored.
            PRESSED: begin
                timer_clear_c = 1'b1;
                if (sync_rows[row]) begin
                    state_next = RELEASE;
                end
            end

            RELEASE: begin
                if (!sync_rows[row]) begin
                    state_next    = PRESSED;
                    timer_clear_c = 1'b1;
                end else if (timer_done_c) begin
                    state_next    = SCAN;
                    col_next      = col + IDX_W'(1);
                    timer_clear_c = 1'b1;
                end
            end

            default: begin
                state_next    = SCAN;
                timer_clear_c = 1'b1;
            end
        endcase

        held_next = (state_next == PRESSED) || (state_next == RELEASE);
        cols_next = col_drive(col_next);
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Self-checking bench for keypad_scan_ctrl with SETTLE_CYCLES=4 and
// DEBOUNCE_CYCLES=8. A behavioural key matrix turns the column drive into
// row levels; expected key codes are queued on press and popped on strobe.
module tb_keypad_scan_ctrl;

    localparam int unsigned SETTLE = 4;
    localparam int unsigned DEB    = 8;
    localparam int          BUDGET = 200;

    logic        int_osc = 1'b0;
    logic        reset   = 1'b1;
    logic [3:0]  sync_rows;
    logic [3:0]  cols;
    logic [3:0]  key;
    logic        key_valid;
    logic        key_held;

    // Pressed keys, bit index = row*4 + column
    logic [15:0] pressed = '0;

    int          n_checks  = 0;
    int          n_pass    = 0;
    int          valid_cnt = 0;
    logic [3:0]  exp_q [$];

    keypad_scan_ctrl #(
        .SETTLE_CYCLES   (SETTLE),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .int_osc   (int_osc),
        .reset     (reset),
        .sync_rows (sync_rows),
        .cols      (cols),
        .key       (key),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 int_osc = ~int_osc;

    // Key matrix: a row reads low when a pressed key sits on a driven column
    always_comb begin
        sync_rows = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4 + c] && !cols[c]) sync_rows[r] = 1'b0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge int_osc);
    endtask

    task automatic wait_valid(input string tag);
        int i;
        i = 0;
        do begin
            @(negedge int_osc);
            i++;
        end while (!key_valid && i < BUDGET);
        check_eq(tag, 32'(key_valid), 32'd1);
    endtask

    task automatic wait_held_low(input string tag);
        int i;
        i = 0;
        do begin
            @(negedge int_osc);
            i++;
        end while (key_held && i < BUDGET);
        check_eq(tag, 32'(key_held), 32'd0);
    endtask

    task automatic wait_cols(input string tag, input logic [3:0] val);
        int i;
        i = 0;
        do begin
            @(negedge int_osc);
            i++;
        end while (cols != val && i < BUDGET);
        check_eq(tag, 32'(cols), 32'(val));
    endtask

    // Scoreboard: every strobe must match the oldest queued key
    always @(posedge int_osc) begin
        #1;
        if (key_valid) begin
            valid_cnt++;
            if (exp_q.size() == 0) check_eq("spurious_valid", 32'(key_valid), 32'd0);
            else check_eq("key_code", 32'(key), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset, then idle scan walks the columns, four cycles each
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        for (int k = 0; k < 17; k++) begin
            logic [3:0] e;
            e = 4'b1111 ^ (4'b0001 << ((k / 4) % 4));
            check_eq("idle_cols", 32'(cols), 32'(e));
            @(negedge int_osc);
        end
        tick(4);
        check_eq("pre_reset_cols", 32'(cols), 32'(4'b1101));
        #2 reset = 1'b1;
        #1;
        check_eq("arst_cols", 32'(cols), 32'(4'b1110));
        check_eq("arst_key", 32'(key), 32'd0);
        check_eq("arst_valid", 32'(key_valid), 32'd0);
        check_eq("arst_held", 32'(key_held), 32'd0);
        @(negedge int_osc);
        reset = 1'b0;

        // Press '5' (row1/col1), hold, then release
        exp_q.push_back(4'h5);
        pressed[1*4 + 1] = 1'b1;
        wait_valid("press5_valid");
        check_eq("press5_held", 32'(key_held), 32'd1);
        tick(20);
        check_eq("press5_hold", 32'(key_held), 32'd1);
        check_eq("press5_count", 32'(valid_cnt), 32'd1);
        pressed = '0;
        tick(8);
        check_eq("rel5_still_held", 32'(key_held), 32'd1);
        tick(1);
        check_eq("rel5_dropped", 32'(key_held), 32'd0);
        check_eq("rel5_next_col", 32'(cols), 32'(4'b1011));

        // Bounce on 'A' (row0/col3): 3 matching debounce cycles, then open
        wait_cols("bounceA_col0", 4'b1110);
        wait_cols("bounceA_col3", 4'b0111);
        pressed[0*4 + 3] = 1'b1;
        tick(7);
        pressed = '0;
        tick(1);
        check_eq("bounceA_advance", 32'(cols), 32'(4'b1110));
        tick(30);
        check_eq("bounceA_count", 32'(valid_cnt), 32'd1);
        check_eq("bounceA_key", 32'(key), 32'h5);
        check_eq("bounceA_held", 32'(key_held), 32'd0);

        // Hold 'D' (row3/col3) with a 3-cycle release bounce
        exp_q.push_back(4'hD);
        pressed[3*4 + 3] = 1'b1;
        wait_valid("pressD_valid");
        tick(3);
        pressed[3*4 + 3] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check_eq("relbounceD_held", 32'(key_held), 32'd1);
        end
        pressed[3*4 + 3] = 1'b1;
        tick(20);
        check_eq("relbounceD_held_end", 32'(key_held), 32'd1);
        check_eq("relbounceD_count", 32'(valid_cnt), 32'd2);
        pressed = '0;
        wait_held_low("relD_drop");
        check_eq("relD_wrap_col", 32'(cols), 32'(4'b1110));
        check_eq("relD_key", 32'(key), 32'hD);

        // Two rows low on column 0: scan keeps advancing
        pressed[0*4 + 0] = 1'b1;
        pressed[2*4 + 0] = 1'b1;
        wait_cols("multi_col0", 4'b1110);
        tick(4);
        check_eq("multi_advance", 32'(cols), 32'(4'b1101));
        tick(44);
        check_eq("multi_count", 32'(valid_cnt), 32'd2);
        check_eq("multi_held", 32'(key_held), 32'd0);
        check_eq("multi_key", 32'(key), 32'hD);
        pressed = '0;

        // Reset while '9' (row2/col2) is pressed; still held afterwards
        exp_q.push_back(4'h9);
        pressed[2*4 + 2] = 1'b1;
        wait_valid("press9_valid");
        tick(3);
        #2 reset = 1'b1;
        #1;
        check_eq("rst9_cols", 32'(cols), 32'(4'b1110));
        check_eq("rst9_key", 32'(key), 32'd0);
        check_eq("rst9_valid", 32'(key_valid), 32'd0);
        check_eq("rst9_held", 32'(key_held), 32'd0);
        exp_q.push_back(4'h9);
        @(negedge int_osc);
        reset = 1'b0;
        wait_valid("repress9_valid");
        check_eq("repress9_key", 32'(key), 32'h9);
        pressed = '0;
        wait_held_low("rel9_drop");
        check_eq("final_count", 32'(valid_cnt), 32'd4);
        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
